rle_flash_prefetch: RTL and testbench

- Prefetch buffer between spi_flash_controller (upstream) and the RLE video decoder (downstream).
- Keeps a small first-word-fall-through (FWFT) FIFO of 16-bit RLE words topped up from flash, so the decoder never waits out SPI read latency.
- Owns the stream address: byte address, +2 per word.
- Supports save/rewind for line repeat and clear for frame restart.

---
 rtl/rle_flash_prefetch_if.sv | 29 ++
 rtl/rle_flash_prefetch.sv | 111 +++++++++++
 tb/tb_rle_flash_prefetch.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_flash_prefetch_if.sv
// Bundles the flash-controller request/response signals and the decoder-facing
// word stream of rle_flash_prefetch.
interface rle_flash_prefetch_if #(
  parameter int ADDR_BITS = 24
);
  logic                 spi_start_read;
  logic                 spi_continue_read;
  logic                 spi_stop_read;
  logic [ADDR_BITS-1:0] spi_addr;
  logic                 spi_busy;
  logic [15:0]          spi_data;
  logic                 out_valid;
  logic [15:0]          out_data;
  logic                 out_ready;

  modport master (
    output spi_start_read, spi_continue_read, spi_stop_read, spi_addr,
    input  spi_busy, spi_data,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  spi_start_read, spi_continue_read, spi_stop_read, spi_addr,
    output spi_busy, spi_data,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/rle_flash_prefetch.sv
// FWFT prefetch FIFO of 16-bit RLE words fed from SPI flash, owning the stream
// byte address with save/rewind (line repeat) and clear (frame restart).
module rle_flash_prefetch #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 save_pos,
  input  logic                 rewind,
  input  logic                 clear,
  rle_flash_prefetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, BUSY, PAUSE} state_t;

  state_t               state_q, state_d;
  logic [15:0]          mem_q [DEPTH];
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]        count_q, count_d, post_pop_cnt;
  logic [ADDR_BITS-1:0] fetch_addr_q, head_addr_q, saved_addr_q, restart_addr;
  logic                 flush, pop, push, start, cont, stop;

  assign flush        = rewind | clear;
  assign pop          = (count_q != '0) && bus.out_ready && !flush;
  assign post_pop_cnt = count_q - CW'(pop);
  assign restart_addr = clear ? '0 : saved_addr_q;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    start   = 1'b0;
    cont    = 1'b0;
    stop    = 1'b0;
    if (flush) begin
      stop    = (state_q != IDLE);
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (!bus.spi_busy) begin
          start   = 1'b1;
          state_d = REQ;
        end
        REQ: state_d = BUSY;
        BUSY: if (!bus.spi_busy) begin
          push = 1'b1;
          if (post_pop_cnt + CW'(1) < CW'(DEPTH)) begin
            cont    = 1'b1;
            state_d = REQ;
          end else begin
            state_d = PAUSE;
          end
        end
        PAUSE: if (post_pop_cnt < CW'(DEPTH)) begin
          cont    = 1'b1;
          state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);

  // Pulses are combinational (continue may follow a same-cycle pop), so they
  // are gated by rst_n to stay quiet while reset is held.
  assign bus.spi_start_read    = start & rst_n;
  assign bus.spi_continue_read = cont & rst_n;
  assign bus.spi_stop_read     = stop & rst_n;
  assign bus.spi_addr          = fetch_addr_q;
  assign bus.out_valid         = (count_q != '0);
  assign bus.out_data          = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_addr_q <= '0;
      head_addr_q  <= '0;
      saved_addr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q     <= '0;
        wr_ptr_q     <= '0;
        fetch_addr_q <= restart_addr;
        head_addr_q  <= restart_addr;
        if (clear) saved_addr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q     <= wr_ptr_q + PW'(1);
          fetch_addr_q <= fetch_addr_q + ADDR_BITS'(2);
        end
        if (pop) begin
          rd_ptr_q    <= rd_ptr_q + PW'(1);
          head_addr_q <= head_addr_q + ADDR_BITS'(2);
        end
        if (save_pos) saved_addr_q <= head_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.spi_data;
  end
endmodule

// File: tb/tb_rle_flash_prefetch.sv
// Self-checking bench for rle_flash_prefetch: flash responder returning
// addr ^ 0xA500, directed vectors plus a stream-level consumer model.
module tb_rle_flash_prefetch;
  logic clk = 1'b0;
  logic rst_n, save_pos, rewind, clear;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rle_flash_prefetch_if #(.ADDR_BITS(24)) bus ();

  rle_flash_prefetch #(.DEPTH(4), .ADDR_BITS(24)) dut (
    .clk(clk), .rst_n(rst_n), .save_pos(save_pos), .rewind(rewind),
    .clear(clear), .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash responder: busy high for 3 cycles after each start/continue.
  logic [23:0] fm_addr;
  int          fm_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.spi_busy <= 1'b0;
      bus.spi_data <= '0;
      fm_cnt       <= 0;
      fm_addr      <= '0;
    end else if (bus.spi_stop_read) begin
      bus.spi_busy <= 1'b0;
      fm_cnt       <= 0;
    end else if (bus.spi_start_read || bus.spi_continue_read) begin
      fm_addr      <= bus.spi_start_read ? bus.spi_addr : fm_addr + 24'd2;
      bus.spi_busy <= 1'b1;
      fm_cnt       <= 3;
    end else if (fm_cnt != 0) begin
      fm_cnt <= fm_cnt - 1;
      if (fm_cnt == 1) begin
        bus.spi_busy <= 1'b0;
        bus.spi_data <= fm_addr[15:0] ^ 16'hA500;
      end
    end
  end

  // Consumer-side reference: the stream is sequential words from a position
  // that save/rewind/clear manipulate.
  logic [23:0] m_head, m_saved;
  bit          flush_prev;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_head = '0; m_saved = '0; flush_prev = 1'b0;
    end else begin
      if (flush_prev) chk("empty_after_flush", bus.out_valid, 1'b0);
      chk("pulse_onehot", 32'(bus.spi_start_read) + 32'(bus.spi_continue_read)
                          + 32'(bus.spi_stop_read) <= 1, 1'b1);
      if (bus.spi_start_read) chk("start_while_idle_bus", bus.spi_busy, 1'b0);
      if (!bus.out_valid && !clear && !rewind)
        chk("gap_has_refill", bus.spi_busy | bus.spi_start_read | bus.spi_continue_read, 1'b1);
      if (clear) begin
        m_head = '0; m_saved = '0;
      end else if (rewind) begin
        m_head = m_saved;
      end else begin
        if (save_pos) m_saved = m_head;
        if (bus.out_valid && bus.out_ready) begin
          chk("stream_word", bus.out_data, m_head[15:0] ^ 16'hA500);
          m_head = m_head + 24'd2;
        end
      end
      flush_prev = clear | rewind;
    end
  end

  typedef struct {
    bit          ready;
    bit          start;
    bit          cont;
    bit          stop;
    logic [23:0] addr;
    bit          valid;
    logic [15:0] data;
  } vec_t;
  vec_t tbl[21];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_word(input logic [15:0] exp);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pop_wait_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    #1 chk("pop_data", bus.out_data, exp);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_start(input logic [23:0] exp_addr);
    bit found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.spi_start_read) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("start_seen", found, 1'b1);
    chk("start_addr", bus.spi_addr, exp_addr);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp;
    int          pops;
    int          r;

    for (int i = 0; i < 21; i++) tbl[i] = '{0, 0, 0, 0, 24'h0, (i >= 5), 16'hA500};
    tbl[0].start  = 1'b1;
    tbl[4].cont   = 1'b1;
    tbl[8].cont   = 1'b1;
    tbl[12].cont  = 1'b1;
    tbl[20].ready = 1'b1;
    tbl[20].cont  = 1'b1;

    rst_n = 1'b0; save_pos = 1'b0; rewind = 1'b0; clear = 1'b0;
    bus.out_ready = 1'b0;
    tick(3);
    #1 chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_start", bus.spi_start_read, 1'b0);
    chk("reset_addr", bus.spi_addr, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill from reset, then one pop from full.
    for (int i = 0; i < 21; i++) begin
      bus.out_ready = tbl[i].ready;
      #1;
      chk($sformatf("v%0d_start", i), bus.spi_start_read, tbl[i].start);
      chk($sformatf("v%0d_cont", i), bus.spi_continue_read, tbl[i].cont);
      chk($sformatf("v%0d_stop", i), bus.spi_stop_read, tbl[i].stop);
      chk($sformatf("v%0d_valid", i), bus.out_valid, tbl[i].valid);
      if (tbl[i].start) chk($sformatf("v%0d_addr", i), bus.spi_addr, tbl[i].addr);
      if (tbl[i].valid) chk($sformatf("v%0d_data", i), bus.out_data, tbl[i].data);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    pop_word(16'hA502);
    pop_word(16'hA504);
    pop_word(16'hA506);
    pop_word(16'hA508);

    // Continuous draining of 64 words.
    exp = 16'hA50A;
    pops = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 600 && pops < 64; n++) begin
      #1;
      if (bus.out_valid) begin
        chk("seq_word", bus.out_data, exp);
        exp = exp + 16'd2;
        pops++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("seq_count", pops, 64);

    // Save at head 0x000004, pop five more, rewind.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pop_word(16'hA500);
    pop_word(16'hA502);
    save_pos = 1'b1;
    @(negedge clk);
    save_pos = 1'b0;
    for (int k = 0; k < 5; k++) pop_word(16'hA504 + 16'(2 * k));
    rewind = 1'b1;
    #1 chk("rewind_stop", bus.spi_stop_read, 1'b1);
    @(negedge clk);
    rewind = 1'b0;
    #1 chk("rewind_empty", bus.out_valid, 1'b0);
    wait_start(24'h000004);
    pop_word(16'hA504);

    // Rewind in the cycle the arriving word lands.
    r = 0;
    while (fm_cnt != 1 && r < 40) begin
      @(negedge clk);
      r++;
    end
    chk("busy_fall_found", fm_cnt, 1);
    @(negedge clk);
    rewind = 1'b1;
    #1 chk("late_rewind_stop", bus.spi_stop_read, 1'b1);
    chk("late_rewind_nocont", bus.spi_continue_read, 1'b0);
    @(negedge clk);
    rewind = 1'b0;
    #1 chk("late_rewind_empty", bus.out_valid, 1'b0);
    wait_start(24'h000004);
    pop_word(16'hA504);

    // Clear in PAUSE, empty pop, then confirm saved position was zeroed.
    tick(24);
    #1 chk("pause_nostart", bus.spi_start_read, 1'b0);
    chk("pause_nocont", bus.spi_continue_read, 1'b0);
    chk("pause_full", bus.out_valid, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    #1 chk("clear_stop", bus.spi_stop_read, 1'b1);
    @(negedge clk);
    clear = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("clear_empty", bus.out_valid, 1'b0);
    wait_start(24'h000000);
    bus.out_ready = 1'b0;
    pop_word(16'hA500);
    pop_word(16'hA502);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    wait_start(24'h000000);
    pop_word(16'hA500);

    // Random consumer traffic against the stream model.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 199));
      bus.out_ready = 1'($urandom_range(0, 1));
      save_pos = (r < 6);
      rewind   = (r == 6 || r == 7);
      clear    = (r == 8);
      @(negedge clk);
    end
    bus.out_ready = 1'b0; save_pos = 1'b0; rewind = 1'b0; clear = 1'b0;
    tick(2);

    // Reset in the middle of a read.
    rst_n = 1'b0;
    #1 chk("rst_nostop", bus.spi_stop_read, 1'b0);
    chk("rst_nostart", bus.spi_start_read, 1'b0);
    chk("rst_nocont", bus.spi_continue_read, 1'b0);
    @(negedge clk);
    #1 chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_addr", bus.spi_addr, 24'h0);
    tick(2);
    rst_n = 1'b1;
    wait_start(24'h000000);
    pop_word(16'hA500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
